// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter: FSM encoding,
// payload geometry and the default frame-group header.
package result_uart_tx_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  localparam int unsigned PAYLOAD_BYTES = 7;
  localparam int unsigned PAYLOAD_W     = PAYLOAD_BYTES * 8;
  localparam logic [2:0]  LAST_BYTE_IDX = 3'd6;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  // Payload is packed first-byte-first in the top bits, so the byte on the
  // wire is always the top byte of the (left-shifting) payload register.
  function automatic logic [PAYLOAD_W-1:0] build_payload(
    input logic [7:0]  header,
    input logic [31:0] tc,
    input logic [15:0] kv
  );
    return {header, tc, kv};
  endfunction

endpackage

// File: rtl/result_uart_tx_baud_tick_gen.sv
// Baud timing: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on
// the last cycle of each bit period.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_MAX);

  // Bit-period counter; clear has priority so each bit starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == CNT_MAX) cnt <= '0;
      else                cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Sends a 7-byte result group (header, trans_count, k_val) as back-to-back
// 8N1 UART characters, then pulses txFinish for one cycle.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tx,
  input  logic [31:0] trans_count,
  input  logic [15:0] k_val,
  output logic        tx,
  output logic        busy,
  output logic        txFinish
);

  logic [STATE_W-1:0]   state;
  logic [2:0]           bit_idx;
  logic [2:0]           byte_idx;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [7:0]           cur_byte;
  logic                 accept;
  logic                 baud_tick;
  logic                 next_byte;

  assign busy     = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
  assign txFinish = (state == ST_DONE);
  // DONE is also a legal accept point so groups can run back-to-back.
  assign accept   = start_tx && ((state == ST_IDLE) || (state == ST_DONE));
  assign cur_byte = payload_q[PAYLOAD_W-1 -: 8];
  assign next_byte = (state == ST_STOP) && baud_tick && (byte_idx < LAST_BYTE_IDX);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .clear  (!busy),
    .tick   (baud_tick)
  );

  // Payload snapshot on accept; shifts one byte left as each stop bit ends.
  always_ff @(posedge clk) begin
    if (accept) begin
      payload_q <= build_payload(HEADER_BYTE, trans_count, k_val);
    end else if (next_byte) begin
      payload_q <= {payload_q[PAYLOAD_W-9:0], 8'h00};
    end
  end

  // Framing FSM; tx is registered so every bit edge lines up with a state edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bit_idx  <= 3'd0;
          byte_idx <= 3'd0;
          if (start_tx) begin
            state <= ST_START;
            tx    <= 1'b0;
          end else begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
            tx      <= cur_byte[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            bit_idx <= 3'd0;
            if (byte_idx < LAST_BYTE_IDX) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_START;
              tx       <= 1'b0;
            end else begin
              byte_idx <= 3'd0;
              state    <= ST_DONE;
              tx       <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          bit_idx  <= 3'd0;
          byte_idx <= 3'd0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx with CLKS_PER_BIT=4.
module tb_result_uart_tx;

  localparam int CPB      = 4;
  localparam int GROUP_CY = 70 * CPB;

  logic        clk;
  logic        rst_n;
  logic        start_tx;
  logic [31:0] trans_count;
  logic [15:0] k_val;
  logic        tx;
  logic        busy;
  logic        txFinish;

  int checks;
  int errors;
  int fin_count;

  result_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_tx    (start_tx),
    .trans_count (trans_count),
    .k_val       (k_val),
    .tx          (tx),
    .busy        (busy),
    .txFinish    (txFinish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && txFinish) fin_count = fin_count + 1;
  end

  // Reference: the i-th byte of a group, straight from the field ordering.
  function automatic logic [7:0] exp_byte(input logic [31:0] tc, input logic [15:0] kv, input int i);
    case (i)
      0:       return 8'hA5;
      1:       return tc[31:24];
      2:       return tc[23:16];
      3:       return tc[15:8];
      4:       return tc[7:0];
      5:       return kv[15:8];
      default: return kv[7:0];
    endcase
  endfunction

  // Reference: line level k cycles after the first start-bit cycle.
  function automatic logic exp_bit(input logic [31:0] tc, input logic [15:0] kv, input int k);
    int bitpos;
    int pos;
    logic [7:0] b;
    bitpos = k / CPB;
    pos    = bitpos % 10;
    b      = exp_byte(tc, kv, bitpos / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_tx = 1'b0; trans_count = '0; k_val = '0;
    #12;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (txFinish !== 1'b0) begin errors++; $display("FAIL reset_fin got=%b exp=0", txFinish); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || txFinish !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset tx=%b busy=%b fin=%b exp 1/0/0", tx, busy, txFinish);
      end
    end
  endtask

  // One full group, checked cycle by cycle and also decoded at mid-bit.
  task automatic test_frame(input logic [31:0] tc, input logic [15:0] kv);
    logic [7:0] dec [7];
    int bitpos;
    int pos;
    trans_count = tc; k_val = kv; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < GROUP_CY; k++) begin
      checks++;
      if (tx !== exp_bit(tc, kv, k) || busy !== 1'b1 || txFinish !== 1'b0) begin
        errors++;
        $display("FAIL frame_wave k=%0d tx=%b busy=%b fin=%b exp tx=%b busy=1 fin=0",
                 k, tx, busy, txFinish, exp_bit(tc, kv, k));
      end
      if ((k % CPB) == CPB / 2) begin
        bitpos = k / CPB;
        pos    = bitpos % 10;
        if (pos >= 1 && pos <= 8) dec[bitpos / 10][pos-1] = tx;
      end
      tick();
    end
    checks++;
    if (txFinish !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL frame_done fin=%b busy=%b tx=%b exp 1/0/1", txFinish, busy, tx);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dec[i] !== exp_byte(tc, kv, i)) begin
        errors++; $display("FAIL frame_byte%0d got=%h exp=%h", i, dec[i], exp_byte(tc, kv, i));
      end
    end
    tick();
    checks++;
    if (txFinish !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL frame_idle fin=%b busy=%b tx=%b exp 0/0/1", txFinish, busy, tx);
    end
  endtask

  task automatic test_known_and_random();
    test_frame(32'h12345678, 16'hBEEF);
    test_frame(32'h0, 16'h0);
    for (int i = 0; i < 3; i++) test_frame($urandom, 16'($urandom));
  endtask

  task automatic test_ignore_busy();
    logic [31:0] tc;
    logic [15:0] kv;
    int f0;
    tc = $urandom; kv = 16'($urandom);
    f0 = fin_count;
    trans_count = tc; k_val = kv; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < GROUP_CY; k++) begin
      checks++;
      if (tx !== exp_bit(tc, kv, k)) begin
        errors++; $display("FAIL ignore_wave k=%0d got=%b exp=%b", k, tx, exp_bit(tc, kv, k));
      end
      start_tx = (k == 49);
      if (k == 49) begin trans_count = ~tc; k_val = ~kv; end
      tick();
    end
    start_tx = 1'b0;
    for (int i = 0; i < GROUP_CY + 20; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL ignore_second_group i=%0d tx=%b busy=%b exp 1/0", i, tx, busy);
      end
    end
    checks++;
    if (fin_count - f0 !== 1) begin
      errors++; $display("FAIL ignore_fin_count got=%0d exp=1", fin_count - f0);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = fin_count;
    trans_count = $urandom; k_val = 16'($urandom); start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < 99; k++) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midrst_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < GROUP_CY + 10; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || txFinish !== 1'b0) begin
        errors++; $display("FAIL midrst_idle i=%0d tx=%b busy=%b fin=%b exp 1/0/0", i, tx, busy, txFinish);
      end
    end
    checks++;
    if (fin_count !== f0) begin
      errors++; $display("FAIL midrst_no_fin got=%0d exp=%0d", fin_count, f0);
    end
    test_frame($urandom, 16'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [31:0] tc_a, tc_b;
    logic [15:0] kv_a, kv_b;
    int f0;
    tc_a = $urandom; kv_a = 16'($urandom);
    tc_b = $urandom; kv_b = 16'($urandom);
    f0 = fin_count;
    trans_count = tc_a; k_val = kv_a; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < GROUP_CY; k++) begin
      checks++;
      if (tx !== exp_bit(tc_a, kv_a, k)) begin
        errors++; $display("FAIL b2b_a k=%0d got=%b exp=%b", k, tx, exp_bit(tc_a, kv_a, k));
      end
      tick();
    end
    checks++;
    if (txFinish !== 1'b1) begin errors++; $display("FAIL b2b_fin_a got=%b exp=1", txFinish); end
    trans_count = tc_b; k_val = kv_b; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < GROUP_CY; k++) begin
      checks++;
      if (tx !== exp_bit(tc_b, kv_b, k) || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_b k=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, exp_bit(tc_b, kv_b, k));
      end
      tick();
    end
    checks++;
    if (txFinish !== 1'b1) begin errors++; $display("FAIL b2b_fin_b got=%b exp=1", txFinish); end
    tick();
    checks++;
    if (fin_count - f0 !== 2) begin
      errors++; $display("FAIL b2b_fin_count got=%0d exp=2", fin_count - f0);
    end
  endtask

  task automatic test_input_change();
    trans_count = 32'h0; k_val = 16'h0; start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    for (int k = 0; k < GROUP_CY; k++) begin
      if (k == 1) begin trans_count = 32'hFFFF_FFFF; k_val = 16'hFFFF; end
      checks++;
      if (tx !== exp_bit(32'h0, 16'h0, k)) begin
        errors++; $display("FAIL hold_inputs k=%0d got=%b exp=%b", k, tx, exp_bit(32'h0, 16'h0, k));
      end
      tick();
    end
    checks++;
    if (txFinish !== 1'b1) begin errors++; $display("FAIL hold_fin got=%b exp=1", txFinish); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; fin_count = 0;
    test_reset();
    test_known_and_random();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_input_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached without completing tests");
    $fatal(1, "timeout");
  end

endmodule
